// File: rtl/qnigma_tmo_mgr_pkg.sv
// qnigma_tmo_pkg: shared state encodings for the timeout manager
package qnigma_tmo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} slot_st_e;
  typedef enum logic {EMPTY, FULL} out_st_e;
endpackage

// File: rtl/qnigma_tmo_mgr_rr_arb.sv
// qnigma_rr_arb: round-robin arbiter, search starts at the slot after the last grant
// Ports: clk, rst (async active-low), req[N] requests, adv commits the current grant,
//        gnt[N] one-hot grant, gnt_id grant index, any = some request present
module qnigma_rr_arb #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  logic [ID_W-1:0] r_ptr;
  // Scan from farthest to nearest so the first requester after r_ptr wins
  always_comb begin
    any = 1'b0;
    gnt_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % N]) begin
        any = 1'b1;
        gnt_id = ID_W'((int'(r_ptr) + k) % N);
      end
    end
    gnt = any ? (N'(1) << gnt_id) : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ptr <= '0;
    else if (adv && any) r_ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
  end
endmodule

// File: rtl/qnigma_tmo_mgr.sv
// qnigma_tmo_mgr: per-slot tick timeouts with a round-robin queued expiry handshake
// Ports: clk, rst (async active-low), tick strobe, arm/arm_id/arm_val, disarm/disarm_id,
//        exp_vld/exp_id/exp_rdy expiry handshake, active[SLOTS] per-slot running flags
module qnigma_tmo_mgr
  import qnigma_tmo_pkg::*;
#(
  parameter  int SLOTS = 4,
  parameter  int TMO_W = 8,
  localparam int ID_W  = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             arm,
  input  logic [ID_W-1:0]  arm_id,
  input  logic [TMO_W-1:0] arm_val,
  input  logic             disarm,
  input  logic [ID_W-1:0]  disarm_id,
  output logic             exp_vld,
  output logic [ID_W-1:0]  exp_id,
  input  logic             exp_rdy,
  output logic [SLOTS-1:0] active
);
  logic [SLOTS-1:0] w_req, w_gnt;
  logic [ID_W-1:0]  w_gid, w_id_nx, r_id;
  logic             w_any, w_load;
  out_st_e          r_ost, w_ost_nx;
  qnigma_rr_arb #(.N(SLOTS)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (w_req),
    .adv    (w_load),
    .gnt    (w_gnt),
    .gnt_id (w_gid),
    .any    (w_any)
  );
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_st_e         r_st, w_st_nx;
    logic [TMO_W-1:0] r_cnt, w_cnt_nx;
    logic             w_arm, w_dis;
    // Arm beats disarm, load and tick; a loaded expiry is already committed to the output
    always_comb begin
      w_arm = arm && arm_id == ID_W'(i);
      w_dis = disarm && disarm_id == ID_W'(i);
      w_st_nx = r_st;
      w_cnt_nx = r_cnt;
      if (w_arm) begin
        w_st_nx = arm_val == '0 ? PEND : RUN;
        w_cnt_nx = arm_val;
      end else if (w_dis || (w_load && w_gnt[i])) begin
        w_st_nx = IDLE;
        w_cnt_nx = '0;
      end else if (r_st == RUN && tick) begin
        w_st_nx = r_cnt == TMO_W'(1) ? PEND : RUN;
        w_cnt_nx = r_cnt - 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_st <= IDLE;
        r_cnt <= '0;
      end else begin
        r_st <= w_st_nx;
        r_cnt <= w_cnt_nx;
      end
    end
    assign w_req[i] = r_st == PEND;
    assign active[i] = r_st == RUN;
  end
  // Accept and reload on the same edge keeps back-to-back expiries gapless
  always_comb begin
    w_load = (r_ost == EMPTY || exp_rdy) && w_any;
    w_ost_nx = w_load ? FULL : (exp_rdy ? EMPTY : r_ost);
    w_id_nx = w_load ? w_gid : r_id;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ost <= EMPTY;
      r_id <= '0;
    end else begin
      r_ost <= w_ost_nx;
      r_id <= w_id_nx;
    end
  end
  assign exp_vld = r_ost == FULL;
  assign exp_id = r_id;
endmodule

// File: tb/tb_qnigma_tmo_mgr.sv
// tb_qnigma_tmo_mgr: directed stimulus with a queued expiry scoreboard
module tb_qnigma_tmo_mgr;
  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, arm = 1'b0, disarm = 1'b0, exp_rdy = 1'b1;
  logic [1:0] arm_id = '0, disarm_id = '0, exp_id;
  logic [7:0] arm_val = '0;
  logic       exp_vld;
  logic [3:0] active;
  int         n_chk = 0, n_fail = 0;
  logic [1:0] q[$];
  logic       p_stall = 1'b0;
  logic [1:0] p_id = '0;

  qnigma_tmo_mgr #(.SLOTS(4), .TMO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .arm       (arm),
    .arm_id    (arm_id),
    .arm_val   (arm_val),
    .disarm    (disarm),
    .disarm_id (disarm_id),
    .exp_vld   (exp_vld),
    .exp_id    (exp_id),
    .exp_rdy   (exp_rdy),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0;
    arm = 1'b0;
    disarm = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] id, input logic [7:0] v, input logic t);
    arm = 1'b1;
    arm_id = id;
    arm_val = v;
    tick = t;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_vld", 32'(exp_vld), 0);
    chk("reset_active", 32'(active), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) p_stall = 1'b0;
    else begin
      if (p_stall) begin
        n_chk++;
        if (!exp_vld || exp_id !== p_id) begin
          n_fail++;
          $display("FAIL stall_hold: vld=%0b id=%0d expected vld=1 id=%0d", exp_vld, exp_id, p_id);
        end
      end
      if (exp_vld && exp_rdy) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_expiry: id=%0d with nothing expected", exp_id);
        end else begin
          logic [1:0] e;
          e = q.pop_front();
          if (exp_id !== e) begin
            n_fail++;
            $display("FAIL expiry_id: got %0d expected %0d", exp_id, e);
          end
        end
      end
      p_stall = exp_vld && !exp_rdy;
      p_id = exp_id;
    end
  end

  initial begin
    do_reset();
    // 1: 3-tick timeout on slot 2 with sparse ticks
    q.push_back(2'd2);
    do_arm(2'd2, 8'd3, 1'b0);
    chk("t1_active_on", 32'(active), 32'h4);
    for (int t = 0; t < 3; t++) begin
      repeat (9) step();
      chk("t1_no_early", 32'(exp_vld), 0);
      do_tick();
    end
    chk("t1_active_off", 32'(active), 0);
    chk("t1_latency_gap", 32'(exp_vld), 0);
    step();
    chk("t1_vld", 32'(exp_vld), 1);
    chk("t1_id", 32'(exp_id), 2);
    // 2: zero timeout expires two edges after arm, single-cycle pulse
    q.push_back(2'd1);
    do_arm(2'd1, 8'd0, 1'b0);
    chk("t2_edge1", 32'(exp_vld), 0);
    step();
    chk("t2_vld", 32'(exp_vld), 1);
    chk("t2_id", 32'(exp_id), 1);
    step();
    chk("t2_pulse", 32'(exp_vld), 0);
    // 3: all slots expire together, stalled then drained round-robin
    do_reset();
    exp_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      q.push_back(2'(s));
      do_arm(2'(s), 8'd1, 1'b0);
    end
    chk("t3_all_active", 32'(active), 32'hf);
    do_tick();
    step();
    repeat (20) step();
    chk("t3_stall_vld", 32'(exp_vld), 1);
    chk("t3_stall_id", 32'(exp_id), 0);
    exp_rdy = 1'b1;
    for (int s = 1; s < 4; s++) begin
      step();
      chk("t3_b2b_vld", 32'(exp_vld), 1);
      chk("t3_b2b_id", 32'(exp_id), s);
    end
    step();
    chk("t3_drained", 32'(exp_vld), 0);
    // 4: disarm plus re-arm in one cycle restarts with the new value
    do_arm(2'd0, 8'd2, 1'b0);
    do_tick();
    disarm = 1'b1;
    disarm_id = 2'd0;
    do_arm(2'd0, 8'd5, 1'b0);
    chk("t4_active", 32'(active), 32'h1);
    repeat (4) do_tick();
    step();
    chk("t4_no_early", 32'(exp_vld), 0);
    q.push_back(2'd0);
    do_tick();
    step();
    chk("t4_vld", 32'(exp_vld), 1);
    chk("t4_id", 32'(exp_id), 0);
    // 5: arm and tick together skip the decrement; disarm in RUN cancels
    do_arm(2'd3, 8'd1, 1'b1);
    step();
    chk("t5_no_dec", 32'(exp_vld), 0);
    chk("t5_active", 32'(active), 32'h8);
    q.push_back(2'd3);
    do_tick();
    step();
    chk("t5_vld", 32'(exp_vld), 1);
    chk("t5_id", 32'(exp_id), 3);
    do_arm(2'd3, 8'd2, 1'b0);
    do_tick();
    disarm = 1'b1;
    disarm_id = 2'd3;
    step();
    chk("t5_disarm_active", 32'(active), 0);
    do_tick();
    repeat (3) step();
    chk("t5_no_expiry", 32'(exp_vld), 0);
    // 6: async reset while stalled on pending expiries
    exp_rdy = 1'b0;
    do_arm(2'd1, 8'd0, 1'b0);
    do_arm(2'd2, 8'd0, 1'b0);
    step();
    chk("t6_pending_vld", 32'(exp_vld), 1);
    chk("t6_pending_id", 32'(exp_id), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_clear", 32'(exp_vld), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rdy = 1'b1;
    repeat (5) step();
    chk("t6_no_expiry", 32'(exp_vld), 0);
    chk("t6_active", 32'(active), 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
